pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 54 +++++
 rtl/pipe_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage decode inputs and pipeline-register outputs of the hazard controller.
// The master side drives decoded instructions; the slave side is the controller.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             valid_ID;
    logic [4:0]       rs1_ID;
    logic [4:0]       rs2_ID;
    logic [4:0]       rd_ID;
    logic             uses_rs1_ID;
    logic             uses_rs2_ID;
    logic             reg_write_ID;
    logic             mem_read_ID;
    logic             mem_write_ID;
    logic             branch_taken_EX;
    logic             hold;

    logic             stall_IF;
    logic             stall_ID;
    logic             flush_ID;
    logic [4:0]       rs1_EX;
    logic [4:0]       rs2_EX;
    logic [4:0]       rd_EX;
    logic             valid_EX;
    logic             reg_write_EX;
    logic             mem_read_EX;
    logic             mem_write_EX;
    logic             valid_MEM;
    logic             reg_write_MEM;
    logic             mem_read_MEM;
    logic [4:0]       rd_MEM;
    logic             valid_WB;
    logic             reg_write_WB;
    logic [4:0]       rd_WB;
    logic [CNT_W-1:0] load_use_cnt;

    modport master (
        output valid_ID, rs1_ID, rs2_ID, rd_ID, uses_rs1_ID, uses_rs2_ID,
               reg_write_ID, mem_read_ID, mem_write_ID, branch_taken_EX, hold,
        input  stall_IF, stall_ID, flush_ID, rs1_EX, rs2_EX, rd_EX,
               valid_EX, reg_write_EX, mem_read_EX, mem_write_EX,
               valid_MEM, reg_write_MEM, mem_read_MEM, rd_MEM,
               valid_WB, reg_write_WB, rd_WB, load_use_cnt
    );

    modport slave (
        input  valid_ID, rs1_ID, rs2_ID, rd_ID, uses_rs1_ID, uses_rs2_ID,
               reg_write_ID, mem_read_ID, mem_write_ID, branch_taken_EX, hold,
        output stall_IF, stall_ID, flush_ID, rs1_EX, rs2_EX, rd_EX,
               valid_EX, reg_write_EX, mem_read_EX, mem_write_EX,
               valid_MEM, reg_write_MEM, mem_read_MEM, rd_MEM,
               valid_WB, reg_write_WB, rd_WB, load_use_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Load-use / branch hazard controller for a 5-stage pipeline, owning the
// ID/EX, EX/MEM and MEM/WB control registers plus a saturating stall counter.
module pipe_hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } idex_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic [4:0] rd;
    } exmem_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [4:0] rd;
    } memwb_t;

    idex_t            ex_q;
    idex_t            ex_d;
    exmem_t           mem_q;
    memwb_t           wb_q;
    logic [CNT_W-1:0] cnt_q;
    logic             load_use;
    logic             bubble;
    logic             cnt_inc;

    always_comb begin
        load_use = bus.valid_ID & ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
                   ((bus.uses_rs1_ID & (bus.rs1_ID == ex_q.rd)) |
                    (bus.uses_rs2_ID & (bus.rs2_ID == ex_q.rd)));
    end

    // Priority: hold, then branch redirect, then load-use
    always_comb begin
        bus.stall_IF = 1'b0;
        bus.stall_ID = 1'b0;
        bus.flush_ID = 1'b0;
        if (bus.hold) begin
            bus.stall_IF = 1'b1;
            bus.stall_ID = 1'b1;
        end else if (bus.branch_taken_EX) begin
            bus.flush_ID = 1'b1;
        end else if (load_use) begin
            bus.stall_IF = 1'b1;
            bus.stall_ID = 1'b1;
        end
    end

    always_comb begin
        bubble  = bus.branch_taken_EX | load_use | ~bus.valid_ID;
        cnt_inc = ~bus.hold & ~bus.branch_taken_EX & load_use & (cnt_q != '1);
        ex_d    = '0;
        if (!bubble) begin
            ex_d.valid     = 1'b1;
            ex_d.reg_write = bus.reg_write_ID & (bus.rd_ID != '0);
            ex_d.mem_read  = bus.mem_read_ID;
            ex_d.mem_write = bus.mem_write_ID;
            ex_d.rs1       = bus.rs1_ID;
            ex_d.rs2       = bus.rs2_ID;
            ex_d.rd        = bus.rd_ID;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else if (!bus.hold) begin
            ex_q  <= ex_d;
            mem_q <= '{valid: ex_q.valid, reg_write: ex_q.reg_write,
                       mem_read: ex_q.mem_read, rd: ex_q.rd};
            wb_q  <= '{valid: mem_q.valid, reg_write: mem_q.reg_write, rd: mem_q.rd};
            if (cnt_inc) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        bus.valid_EX      = ex_q.valid;
        bus.reg_write_EX  = ex_q.reg_write;
        bus.mem_read_EX   = ex_q.mem_read;
        bus.mem_write_EX  = ex_q.mem_write;
        bus.rs1_EX        = ex_q.rs1;
        bus.rs2_EX        = ex_q.rs2;
        bus.rd_EX         = ex_q.rd;
        bus.valid_MEM     = mem_q.valid;
        bus.reg_write_MEM = mem_q.reg_write;
        bus.mem_read_MEM  = mem_q.mem_read;
        bus.rd_MEM        = mem_q.rd;
        bus.valid_WB      = wb_q.valid;
        bus.reg_write_WB  = wb_q.reg_write;
        bus.rd_WB         = wb_q.rd;
        bus.load_use_cnt  = cnt_q;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized bench for pipe_hazard_ctrl (16-bit and 2-bit counter
// instances) against an instruction-record pipeline model.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_ID;
    logic [4:0] rs1_ID, rs2_ID, rd_ID;
    logic       uses_rs1_ID, uses_rs2_ID;
    logic       reg_write_ID, mem_read_ID, mem_write_ID;
    logic       branch_taken_EX, hold;

    int n_assert = 0;
    int n_fail   = 0;

    pipe_hazard_ctrl_if #(.CNT_W(16)) if16 ();
    pipe_hazard_ctrl_if #(.CNT_W(2))  if2 ();

    assign if16.valid_ID        = valid_ID;
    assign if16.rs1_ID          = rs1_ID;
    assign if16.rs2_ID          = rs2_ID;
    assign if16.rd_ID           = rd_ID;
    assign if16.uses_rs1_ID     = uses_rs1_ID;
    assign if16.uses_rs2_ID     = uses_rs2_ID;
    assign if16.reg_write_ID    = reg_write_ID;
    assign if16.mem_read_ID     = mem_read_ID;
    assign if16.mem_write_ID    = mem_write_ID;
    assign if16.branch_taken_EX = branch_taken_EX;
    assign if16.hold            = hold;
    assign if2.valid_ID         = valid_ID;
    assign if2.rs1_ID           = rs1_ID;
    assign if2.rs2_ID           = rs2_ID;
    assign if2.rd_ID            = rd_ID;
    assign if2.uses_rs1_ID      = uses_rs1_ID;
    assign if2.uses_rs2_ID      = uses_rs2_ID;
    assign if2.reg_write_ID     = reg_write_ID;
    assign if2.mem_read_ID      = mem_read_ID;
    assign if2.mem_write_ID     = mem_write_ID;
    assign if2.branch_taken_EX  = branch_taken_EX;
    assign if2.hold             = hold;

    pipe_hazard_ctrl #(.CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
    pipe_hazard_ctrl #(.CNT_W(2))  dut2  (.clk(clk), .rst(rst), .bus(if2));

    always #5 clk = ~clk;

    // Model: one record per in-flight instruction, index 0 = EX, 1 = MEM, 2 = WB
    typedef struct {
        bit       v, rw, mr, mw;
        bit [4:0] rs1, rs2, rd;
    } ins_t;

    ins_t        m_pipe[3];
    int unsigned m_cnt16, m_cnt2;

    function automatic ins_t empty_ins();
        ins_t e;
        e = '{v: 0, rw: 0, mr: 0, mw: 0, rs1: 0, rs2: 0, rd: 0};
        return e;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) m_pipe[i] = empty_ins();
        m_cnt16 = 0;
        m_cnt2  = 0;
    endtask

    function automatic bit model_lu();
        ins_t ex = m_pipe[0];
        return valid_ID && ex.v && ex.mr && ex.rd != 0 &&
               ((uses_rs1_ID && rs1_ID == ex.rd) || (uses_rs2_ID && rs2_ID == ex.rd));
    endfunction

    task automatic model_edge();
        bit   lu;
        ins_t n;
        if (rst) begin
            model_clear();
        end else if (!hold) begin
            lu = model_lu();
            n  = empty_ins();
            if (!branch_taken_EX && !lu && valid_ID)
                n = '{v: 1, rw: reg_write_ID && rd_ID != 0, mr: mem_read_ID, mw: mem_write_ID,
                      rs1: rs1_ID, rs2: rs2_ID, rd: rd_ID};
            m_pipe[2] = m_pipe[1];
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = n;
            if (lu && !branch_taken_EX) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        bit e_stall, e_flush;
        e_stall = hold || (!branch_taken_EX && model_lu());
        e_flush = !hold && branch_taken_EX;
        chk({tag, ".stall_IF"}, if16.stall_IF, e_stall);
        chk({tag, ".stall_ID"}, if16.stall_ID, e_stall);
        chk({tag, ".flush_ID"}, if16.flush_ID, e_flush);
        chk({tag, ".valid_EX"}, if16.valid_EX, m_pipe[0].v);
        chk({tag, ".reg_write_EX"}, if16.reg_write_EX, m_pipe[0].rw);
        chk({tag, ".mem_read_EX"}, if16.mem_read_EX, m_pipe[0].mr);
        chk({tag, ".mem_write_EX"}, if16.mem_write_EX, m_pipe[0].mw);
        chk({tag, ".rs1_EX"}, if16.rs1_EX, m_pipe[0].rs1);
        chk({tag, ".rs2_EX"}, if16.rs2_EX, m_pipe[0].rs2);
        chk({tag, ".rd_EX"}, if16.rd_EX, m_pipe[0].rd);
        chk({tag, ".valid_MEM"}, if16.valid_MEM, m_pipe[1].v);
        chk({tag, ".reg_write_MEM"}, if16.reg_write_MEM, m_pipe[1].rw);
        chk({tag, ".mem_read_MEM"}, if16.mem_read_MEM, m_pipe[1].mr);
        chk({tag, ".rd_MEM"}, if16.rd_MEM, m_pipe[1].rd);
        chk({tag, ".valid_WB"}, if16.valid_WB, m_pipe[2].v);
        chk({tag, ".reg_write_WB"}, if16.reg_write_WB, m_pipe[2].rw);
        chk({tag, ".rd_WB"}, if16.rd_WB, m_pipe[2].rd);
        chk({tag, ".cnt16"}, if16.load_use_cnt, m_cnt16);
        chk({tag, ".cnt2"}, if2.load_use_cnt, m_cnt2);
        chk({tag, ".cnt2_stall"}, if2.stall_IF, e_stall);
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_id(input bit v, input bit [4:0] r1, input bit [4:0] r2, input bit [4:0] d,
                          input bit u1, input bit u2, input bit rw, input bit mr, input bit mw);
        valid_ID = v; rs1_ID = r1; rs2_ID = r2; rd_ID = d;
        uses_rs1_ID = u1; uses_rs2_ID = u2;
        reg_write_ID = rw; mem_read_ID = mr; mem_write_ID = mw;
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; branch_taken_EX = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_clear();

        // Reset state and comb response during reset
        #2;
        check_all("rst_idle");
        hold = 1'b1; #1; check_all("rst_hold");
        hold = 1'b0; branch_taken_EX = 1'b1; #1; check_all("rst_branch");
        branch_taken_EX = 1'b0;
        set_id(1, 3, 4, 5, 1, 1, 1, 0, 0);
        cycle("rst_edge");
        rst = 1'b0;

        // Load x5 then consumer on rs2
        set_id(1, 1, 0, 5, 1, 0, 1, 1, 0);
        cycle("lu_load");
        set_id(1, 2, 5, 9, 1, 1, 1, 0, 0);
        #1;
        chk("lu_stall", if16.stall_IF, 1);
        cycle("lu_stall_cyc");
        chk("lu_bubble", if16.valid_EX, 0);
        chk("lu_rd_mem", if16.rd_MEM, 5);
        chk("lu_cnt", if16.load_use_cnt, 1);
        cycle("lu_release");
        chk("lu_advance", if16.rd_EX, 9);

        // Same hazard overridden by a branch
        set_id(1, 0, 0, 6, 0, 0, 1, 1, 0);
        cycle("br_load");
        set_id(1, 6, 0, 10, 1, 0, 1, 0, 0);
        branch_taken_EX = 1'b1;
        #1;
        chk("br_flush", if16.flush_ID, 1);
        chk("br_nostall", if16.stall_IF, 0);
        cycle("br_cyc");
        branch_taken_EX = 1'b0;
        chk("br_bubble", if16.valid_EX, 0);
        chk("br_cnt", if16.load_use_cnt, 1);

        // x0 never hazards and is never written
        set_id(1, 0, 0, 0, 0, 0, 1, 1, 0);
        cycle("x0_load");
        chk("x0_rw", if16.reg_write_EX, 0);
        chk("x0_mr", if16.mem_read_EX, 1);
        set_id(1, 0, 0, 4, 1, 1, 1, 0, 0);
        #1;
        chk("x0_nostall", if16.stall_IF, 0);
        cycle("x0_use");

        // Hold frozen over a pending load-use
        set_id(1, 0, 0, 7, 0, 0, 1, 1, 0);
        cycle("hold_load");
        set_id(1, 1, 7, 8, 0, 1, 1, 0, 0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) cycle("hold_cyc");
        chk("hold_frozen_rd", if16.rd_EX, 7);
        chk("hold_frozen_cnt", if16.load_use_cnt, 1);
        hold = 1'b0;
        cycle("hold_stall");
        chk("hold_bubble", if16.valid_EX, 0);
        chk("hold_cnt", if16.load_use_cnt, 2);
        cycle("hold_adv");
        chk("hold_adv_rd", if16.rd_EX, 8);

        // Counter saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) begin
            set_id(1, 0, 0, 3, 0, 0, 1, 1, 0);
            cycle("sat_load");
            set_id(1, 3, 0, 11, 1, 0, 1, 0, 0);
            cycle("sat_use");
        end
        chk("sat_cnt2", if2.load_use_cnt, 3);
        chk("sat_cnt16", if16.load_use_cnt, 7);

        // Asynchronous reset with a live WB entry
        set_id(1, 0, 0, 7, 0, 0, 1, 0, 0);
        cycle("ar_issue");
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("ar_mem");
        cycle("ar_wb");
        chk("ar_pre_vwb", if16.valid_WB, 1);
        chk("ar_pre_rdwb", if16.rd_WB, 7);
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        check_all("ar_async");
        chk("ar_vwb", if16.valid_WB, 0);
        chk("ar_rdwb", if16.rd_WB, 0);
        rst = 1'b0;
        set_id(1, 1, 2, 3, 1, 1, 1, 0, 0);
        cycle("ar_release");
        chk("ar_capture", if16.rd_EX, 3);

        // Randomized traffic over a small register set to provoke hazards
        for (int i = 0; i < 400; i++) begin
            set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom));
            branch_taken_EX = ($urandom_range(0, 9) == 0);
            hold            = ($urandom_range(0, 9) == 0);
            cycle("rand");
        end
        hold = 1'b0; branch_taken_EX = 1'b0;
        cycle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
